id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- MIPS decode stage: decodes one instruction per cycle, reads the internal 32-entry register file, resolves operands with EX/MEM/WB forwarding, and interlocks on load-use hazards.
- Sits between the IF/ID register and EX. The ID/EX register is inside this block and uses a valid/ready handshake on both sides, so the stage stalls and flushes cleanly.

Parameters:
DATA_W, 32, register and operand width (≥16)
FWD_EN, 1, 1 = forward from EX/MEM/WB; 0 = no forwarding, stall on any in-flight RAW match
WB_BYPASS, 1, 1 = same-cycle WB write is visible to the ID read (write-through)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  kill the ID/EX contents and the current input
in_valid_i  in  1  IF/ID holds an instruction
in_ready_o  out  1  ID accepts the instruction this cycle
pc_i  in  32  instruction PC
inst_i  in  32  instruction word
ex_wreg_i / ex_wd_i / ex_wdata_i / ex_is_load_i  in  1/5/DATA_W/1  EX-stage destination
mem_wreg_i / mem_wd_i / mem_wdata_i  in  1/5/DATA_W  MEM-stage destination
we_i / waddr_i / wdata_i  in  1/5/DATA_W  WB write port
out_valid_o  out  1  ID/EX holds a valid op
out_ready_i  in  1  EX accepts the op
pc_o  out  32  registered PC
aluop_o  out  8  registered ALU op
alusel_o  out  3  registered result select
reg1_o, reg2_o  out  DATA_W  registered operands
imm_o  out  DATA_W  registered extended immediate
wreg_o  out  1  op writes a register
wd_o  out  5  destination register
illegal_o  out  1  undecodable opcode/funct

Behaviour:
Reset (rst_n=0, async)
- All registered outputs go to 0; out_valid_o=0.
- Register file clears to 0.

Decode (op = inst[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0])
- ORI 0x0D / ANDI 0x0C / XORI 0x0E: aluop 0x25/0x24/0x26, alusel 1. Read rs; reg2 = imm zero-extended; wd = rt.
- ADDIU 0x09: aluop 0x21, alusel 2. reg2 = sign-extended imm (inst[15] replicated); wd = rt.
- LUI 0x0F: aluop 0x25, alusel 1. reg1 = 0; reg2 = {imm,16'b0}, truncated/zero-padded to DATA_W; wd = rt.
- LW 0x23: aluop 0xE3, alusel 3. Read rs; imm_o sign-extended; wd = rt.
- SW 0x2B: aluop 0xEB, alusel 3. Read rs and rt; wreg = 0.
- SPECIAL 0x00, funct 0x25/0x24/0x26/0x21/0x23/0x2A: aluop = {2'b00, funct}, alusel 1 for logic, 2 for arith/SLT. Read rs and rt; wd = rd.
- inst == 0 is a NOP: aluop 0, alusel 0, wreg 0.
- Anything else: NOP fields and illegal_o = 1.
- wreg is forced to 0 whenever wd == 0.

Operand resolution, per read port
- Non-read port yields 0 (except immediates as above). Address 0 always yields 0.
- Priority: EX match (ex_wreg && ex_wd == addr) > MEM match > WB match (if WB_BYPASS) > register file.
- With FWD_EN=0, an EX or MEM match raises stall instead of forwarding.

Hazards and handshake
- Load-use: ex_is_load_i && ex_wreg_i && ex_wd_i == any read address ≠ 0 raises stall.
- in_ready_o = flush_i | (~stall & (~out_valid_o | out_ready_i)).
- On clk, if flush_i: out_valid_o <= 0. Input is consumed and discarded.
- Else if in_valid_i & in_ready_o: the ID/EX register loads the decoded fields; out_valid_o <= 1.
- Else if out_ready_i: out_valid_o <= 0, i.e. a bubble (covers stall and empty input).
- Else: hold all outputs unchanged.
- While out_valid_o=1 and out_ready_i=0, outputs must stay stable.

Register file
- Write on clk when we_i && waddr_i ≠ 0.
- With WB_BYPASS=0, the written value is readable from the next cycle.

Test Plan:
1. Reset, then ORI inst 0x3421_00FF with $1=0x1234_0000 → next cycle out_valid=1, aluop 0x25, alusel 1, reg1 0x1234_0000, reg2 0x0000_00FF, wd 1, wreg 1.
2. ADDIU imm 0xFFFE → reg2 0xFFFF_FFFE. LUI imm 0xABCD → reg2 0xABCD_0000, reg1 0.
3. Forwarding: $3 writeback pending with EX wd=3 data 5, MEM wd=3 data 7, WB wd=3 data 9; ADDU $4,$3,$3 → reg1 = reg2 = 5. Drop the EX match → 7. Drop the MEM match → 9.
4. Load-use: EX is LW with wd=2; ID holds OR $5,$2,$0 → in_ready_o=0 and a bubble (out_valid 0). Next cycle with ex_is_load=0 and MEM wd=2 forwarding → accepted with the MEM data.
5. Backpressure: out_ready_i=0 for 3 cycles with in_valid=1 → outputs stable, in_ready_o=0. Release → next op loads, no op lost or duplicated.
6. flush_i asserted with out_valid=1 → out_valid 0 next cycle and the input is discarded. Unknown op 0x3F → illegal_o 1, wreg 0. Writes to $0 never read back as nonzero.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: IF/ID input handshake, EX/MEM/WB bypass taps, ID/EX output handshake.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready_o / out_ready_i carry the valid-ready handshake on each side.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       pc_i;
    logic [31:0]       inst_i;
    logic              ex_wreg_i;
    logic [4:0]        ex_wd_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic              ex_is_load_i;
    logic              mem_wreg_i;
    logic [4:0]        mem_wd_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              we_i;
    logic [4:0]        waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       pc_o;
    logic [7:0]        aluop_o;
    logic [2:0]        alusel_o;
    logic [DATA_W-1:0] reg1_o;
    logic [DATA_W-1:0] reg2_o;
    logic [DATA_W-1:0] imm_o;
    logic              wreg_o;
    logic [4:0]        wd_o;
    logic              illegal_o;

    // Pipeline environment side: drives the stage inputs, observes its outputs.
    modport master (
        output flush_i, in_valid_i, pc_i, inst_i,
        output ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
        output mem_wreg_i, mem_wd_i, mem_wdata_i,
        output we_i, waddr_i, wdata_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, aluop_o, alusel_o,
        input  reg1_o, reg2_o, imm_o, wreg_o, wd_o, illegal_o
    );

    // Decode stage side.
    modport slave (
        input  flush_i, in_valid_i, pc_i, inst_i,
        input  ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
        input  mem_wreg_i, mem_wd_i, mem_wdata_i,
        input  we_i, waddr_i, wdata_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, aluop_o, alusel_o,
        output reg1_o, reg2_o, imm_o, wreg_o, wd_o, illegal_o
    );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: decode, regfile read with EX/MEM/WB forwarding, load-use interlock.
// Latency: 1 cycle from accepted instruction to valid ID/EX output.
// Backpressure: ID/EX holds while out_ready_i=0; in_ready_o drops on stall or full ID/EX.
module id_stage_pipe #(
    parameter int DATA_W    = 32,
    parameter bit FWD_EN    = 1'b1,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    id_stage_pipe_if.slave bus
);
    typedef struct packed {
        logic [31:0]       pc;
        logic [7:0]        aluop;
        logic [2:0]        alusel;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [DATA_W-1:0] imm;
        logic              wreg;
        logic [4:0]        wd;
        logic              illegal;
    } idex_t;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [4:0]  unused_shamt;

    assign op           = bus.inst_i[31:26];
    assign rs           = bus.inst_i[25:21];
    assign rt           = bus.inst_i[20:16];
    assign rd           = bus.inst_i[15:11];
    assign unused_shamt = bus.inst_i[10:6];
    assign funct        = bus.inst_i[5:0];
    assign imm16        = bus.inst_i[15:0];

    logic [DATA_W-1:0] imm_zext, imm_sext, imm_lui;
    assign imm_zext = DATA_W'(imm16);
    assign imm_sext = DATA_W'($signed(imm16));
    assign imm_lui  = DATA_W'({imm16, 16'h0000});

    logic [DATA_W-1:0] rf [32];

    logic              out_vld;
    idex_t             idex_q, idex_d;
    logic              stall;
    logic              in_rdy;

    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic              dec_re1, dec_re2, dec_use_imm, dec_wreg, dec_ill;
    logic [4:0]        dec_wd;
    logic [DATA_W-1:0] dec_imm;

    // Instruction decode: opcode/funct to ALU controls, read enables and destination.
    always_comb begin
        dec_aluop   = 8'h00;
        dec_alusel  = 3'd0;
        dec_re1     = 1'b0;
        dec_re2     = 1'b0;
        dec_use_imm = 1'b0;
        dec_wreg    = 1'b0;
        dec_ill     = 1'b0;
        dec_wd      = 5'd0;
        dec_imm     = '0;
        case (op)
            6'h0D, 6'h0C, 6'h0E: begin
                dec_aluop   = (op == 6'h0D) ? 8'h25 : (op == 6'h0C) ? 8'h24 : 8'h26;
                dec_alusel  = 3'd1;
                dec_re1     = 1'b1;
                dec_use_imm = 1'b1;
                dec_imm     = imm_zext;
                dec_wd      = rt;
                dec_wreg    = 1'b1;
            end
            6'h09: begin
                dec_aluop   = 8'h21;
                dec_alusel  = 3'd2;
                dec_re1     = 1'b1;
                dec_use_imm = 1'b1;
                dec_imm     = imm_sext;
                dec_wd      = rt;
                dec_wreg    = 1'b1;
            end
            6'h0F: begin
                dec_aluop   = 8'h25;
                dec_alusel  = 3'd1;
                dec_use_imm = 1'b1;
                dec_imm     = imm_lui;
                dec_wd      = rt;
                dec_wreg    = 1'b1;
            end
            6'h23: begin
                dec_aluop  = 8'hE3;
                dec_alusel = 3'd3;
                dec_re1    = 1'b1;
                dec_imm    = imm_sext;
                dec_wd     = rt;
                dec_wreg   = 1'b1;
            end
            6'h2B: begin
                dec_aluop  = 8'hEB;
                dec_alusel = 3'd3;
                dec_re1    = 1'b1;
                dec_re2    = 1'b1;
                dec_imm    = imm_sext;
            end
            6'h00: begin
                // An all-zero word is the canonical NOP and leaves every field at zero.
                if (bus.inst_i != 32'h0) begin
                    case (funct)
                        6'h25, 6'h24, 6'h26, 6'h21, 6'h23, 6'h2A: begin
                            dec_aluop  = {2'b00, funct};
                            dec_alusel = (funct == 6'h21 || funct == 6'h23 || funct == 6'h2A) ? 3'd2 : 3'd1;
                            dec_re1    = 1'b1;
                            dec_re2    = 1'b1;
                            dec_wd     = rd;
                            dec_wreg   = 1'b1;
                        end
                        default: dec_ill = 1'b1;
                    endcase
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    logic [1:0][4:0]        raddr;
    logic [1:0]             re;
    logic [1:0][DATA_W-1:0] opnd;
    logic [1:0]             port_stall;

    assign raddr = {rt, rs};
    assign re    = {dec_re2, dec_re1};

    // Operand resolution per read port: youngest producer wins; a load in EX cannot forward yet.
    always_comb begin
        opnd       = '0;
        port_stall = '0;
        for (int p = 0; p < 2; p++) begin
            if (re[p] && raddr[p] != 5'd0) begin
                if (bus.ex_wreg_i && bus.ex_wd_i == raddr[p]) begin
                    if (bus.ex_is_load_i || !FWD_EN) port_stall[p] = 1'b1;
                    else                             opnd[p]       = bus.ex_wdata_i;
                end else if (bus.mem_wreg_i && bus.mem_wd_i == raddr[p]) begin
                    if (!FWD_EN) port_stall[p] = 1'b1;
                    else         opnd[p]       = bus.mem_wdata_i;
                end else if (WB_BYPASS && bus.we_i && bus.waddr_i == raddr[p]) begin
                    opnd[p] = bus.wdata_i;
                end else begin
                    opnd[p] = rf[raddr[p]];
                end
            end
        end
    end

    assign stall  = |port_stall;
    assign in_rdy = bus.flush_i | (~stall & (~out_vld | bus.out_ready_i));

    // Assemble the next ID/EX word; an instruction targeting $0 never writes back.
    always_comb begin
        idex_d         = '0;
        idex_d.pc      = bus.pc_i;
        idex_d.aluop   = dec_aluop;
        idex_d.alusel  = dec_alusel;
        idex_d.reg1    = opnd[0];
        idex_d.reg2    = dec_use_imm ? dec_imm : opnd[1];
        idex_d.imm     = dec_imm;
        idex_d.wreg    = dec_wreg && (dec_wd != 5'd0);
        idex_d.wd      = dec_wd;
        idex_d.illegal = dec_ill;
    end

    // ID/EX register: flush kills, accept loads, drained slot becomes a bubble, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            idex_q  <= '0;
        end else if (bus.flush_i) begin
            out_vld <= 1'b0;
        end else if (bus.in_valid_i && in_rdy) begin
            idex_q  <= idex_d;
            out_vld <= 1'b1;
        end else if (bus.out_ready_i) begin
            out_vld <= 1'b0;
        end
    end

    // Register file write port; $0 stays hard-wired to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (bus.we_i && bus.waddr_i != 5'd0) begin
            rf[bus.waddr_i] <= bus.wdata_i;
        end
    end

    assign bus.in_ready_o  = in_rdy;
    assign bus.out_valid_o = out_vld;
    assign bus.pc_o        = idex_q.pc;
    assign bus.aluop_o     = idex_q.aluop;
    assign bus.alusel_o    = idex_q.alusel;
    assign bus.reg1_o      = idex_q.reg1;
    assign bus.reg2_o      = idex_q.reg2;
    assign bus.imm_o       = idex_q.imm;
    assign bus.wreg_o      = idex_q.wreg;
    assign bus.wd_o        = idex_q.wd;
    assign bus.illegal_o   = idex_q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: vector table through a scoreboard plus hazard sequences.
// Latency: expects each accepted op on the outputs one cycle after acceptance.
// Backpressure: exercises out_ready_i stalls, load-use interlock and flush.
module tb_id_stage_pipe;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(DATA_W)) bus ();

    id_stage_pipe #(.DATA_W(DATA_W), .FWD_EN(1'b1), .WB_BYPASS(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        logic        wreg;
        logic [4:0]  wd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic        ex_en;
        logic        ex_load;
        logic [4:0]  ex_wd;
        logic [31:0] ex_data;
        logic        mem_en;
        logic [4:0]  mem_wd;
        logic [31:0] mem_data;
        logic        wb_en;
        logic [4:0]  wb_wd;
        logic [31:0] wb_data;
        exp_t        exp;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    vec_t tbl[18];
    vec_t lu;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input logic [7:0] aluop,
                                input logic [2:0] alusel, input logic [31:0] reg1,
                                input logic [31:0] reg2, input logic [31:0] imm,
                                input logic [4:0] wd, input logic wreg, input logic ill);
        vec_t v;
        v.inst = inst;
        v.ex_en = 1'b0; v.ex_load = 1'b0; v.ex_wd = 5'd0; v.ex_data = 32'h0;
        v.mem_en = 1'b0; v.mem_wd = 5'd0; v.mem_data = 32'h0;
        v.wb_en = 1'b0; v.wb_wd = 5'd0; v.wb_data = 32'h0;
        v.exp.pc = 32'h0;
        v.exp.aluop = aluop; v.exp.alusel = alusel;
        v.exp.reg1 = reg1; v.exp.reg2 = reg2; v.exp.imm = imm;
        v.exp.wreg = wreg; v.exp.wd = wd; v.exp.ill = ill;
        return v;
    endfunction

    task automatic idle();
        bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.pc_i = 32'h0; bus.inst_i = 32'h0;
        bus.ex_wreg_i = 1'b0; bus.ex_wd_i = 5'd0; bus.ex_wdata_i = '0; bus.ex_is_load_i = 1'b0;
        bus.mem_wreg_i = 1'b0; bus.mem_wd_i = 5'd0; bus.mem_wdata_i = '0;
        bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.wdata_i = '0;
    endtask

    // Drive one instruction until accepted; push its expected ID/EX word when it is.
    task automatic send(input vec_t v, input logic [31:0] pc, input bit push);
        exp_t e;
        bit   done;
        done = 1'b0;
        bus.in_valid_i = 1'b1; bus.pc_i = pc; bus.inst_i = v.inst;
        bus.ex_wreg_i = v.ex_en; bus.ex_wd_i = v.ex_wd; bus.ex_wdata_i = v.ex_data; bus.ex_is_load_i = v.ex_load;
        bus.mem_wreg_i = v.mem_en; bus.mem_wd_i = v.mem_wd; bus.mem_wdata_i = v.mem_data;
        bus.we_i = v.wb_en; bus.waddr_i = v.wb_wd; bus.wdata_i = v.wb_data;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                done = 1'b1;
                if (push) begin
                    e = v.exp;
                    e.pc = pc;
                    sbq.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: pc %h never accepted, required in_ready_o 1", pc);
        end
        idle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
        @(posedge clk);
        #1;
        bus.we_i = 1'b0;
    endtask

    // Scoreboard monitor: every handshaken output op must match the oldest expectation.
    always @(negedge clk) begin
        exp_t got, e;
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            got.pc = bus.pc_o; got.aluop = bus.aluop_o; got.alusel = bus.alusel_o;
            got.reg1 = bus.reg1_o; got.reg2 = bus.reg2_o; got.imm = bus.imm_o;
            got.wreg = bus.wreg_o; got.wd = bus.wd_o; got.ill = bus.illegal_o;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_op: got pc %h aluop %h, required no op", got.pc, got.aluop);
            end else begin
                e = sbq.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL op_pc_%h: got aluop %h sel %0d r1 %h r2 %h imm %h wreg %b wd %0d ill %b pc %h; required aluop %h sel %0d r1 %h r2 %h imm %h wreg %b wd %0d ill %b",
                             e.pc, got.aluop, got.alusel, got.reg1, got.reg2, got.imm, got.wreg, got.wd, got.ill, got.pc,
                             e.aluop, e.alusel, e.reg1, e.reg2, e.imm, e.wreg, e.wd, e.ill);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.out_ready_i = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_pc", 64'(bus.pc_o), 64'd0);
        chk("rst_aluop", 64'(bus.aluop_o), 64'd0);
        chk("rst_reg1", 64'(bus.reg1_o), 64'd0);
        chk("rst_wreg", 64'(bus.wreg_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        wr(5'd1, 32'h1234_0000);
        wr(5'd2, 32'h0000_00F0);
        wr(5'd0, 32'hDEAD_BEEF);

        tbl[0]  = mk(32'h3421_00FF, 8'h25, 3'd1, 32'h1234_0000, 32'h0000_00FF, 32'h0000_00FF, 5'd1, 1'b1, 1'b0);
        tbl[1]  = mk(32'h2407_FFFE, 8'h21, 3'd2, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 5'd7, 1'b1, 1'b0);
        tbl[2]  = mk(32'h3C08_ABCD, 8'h25, 3'd1, 32'h0, 32'hABCD_0000, 32'hABCD_0000, 5'd8, 1'b1, 1'b0);
        tbl[3]  = mk(32'h3049_00FF, 8'h24, 3'd1, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_00FF, 5'd9, 1'b1, 1'b0);
        tbl[4]  = mk(32'h3820_0001, 8'h26, 3'd1, 32'h1234_0000, 32'h1, 32'h1, 5'd0, 1'b0, 1'b0);
        tbl[5]  = mk(32'h0063_2021, 8'h21, 3'd2, 32'h5, 32'h5, 32'h0, 5'd4, 1'b1, 1'b0);
        tbl[5].ex_en = 1'b1;  tbl[5].ex_wd = 5'd3;  tbl[5].ex_data = 32'h5;
        tbl[5].mem_en = 1'b1; tbl[5].mem_wd = 5'd3; tbl[5].mem_data = 32'h7;
        tbl[5].wb_en = 1'b1;  tbl[5].wb_wd = 5'd3;  tbl[5].wb_data = 32'h9;
        tbl[6]  = mk(32'h0063_2021, 8'h21, 3'd2, 32'h7, 32'h7, 32'h0, 5'd4, 1'b1, 1'b0);
        tbl[6].mem_en = 1'b1; tbl[6].mem_wd = 5'd3; tbl[6].mem_data = 32'h7;
        tbl[6].wb_en = 1'b1;  tbl[6].wb_wd = 5'd3;  tbl[6].wb_data = 32'h9;
        tbl[7]  = mk(32'h0063_2021, 8'h21, 3'd2, 32'h99, 32'h99, 32'h0, 5'd4, 1'b1, 1'b0);
        tbl[7].wb_en = 1'b1;  tbl[7].wb_wd = 5'd3;  tbl[7].wb_data = 32'h99;
        tbl[8]  = mk(32'h0061_5023, 8'h23, 3'd2, 32'h99, 32'h1234_0000, 32'h0, 5'd10, 1'b1, 1'b0);
        tbl[9]  = mk(32'h0022_582A, 8'h2A, 3'd2, 32'h1234_0000, 32'h0000_00F0, 32'h0, 5'd11, 1'b1, 1'b0);
        tbl[10] = mk(32'h0022_6024, 8'h24, 3'd1, 32'h1234_0000, 32'h0000_00F0, 32'h0, 5'd12, 1'b1, 1'b0);
        tbl[11] = mk(32'h0022_6826, 8'h26, 3'd1, 32'h1234_0000, 32'h0000_00F0, 32'h0, 5'd13, 1'b1, 1'b0);
        tbl[12] = mk(32'h0000_0000, 8'h00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tbl[13] = mk(32'hFC00_0000, 8'h00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tbl[14] = mk(32'h0022_583F, 8'h00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tbl[15] = mk(32'hAC22_0004, 8'hEB, 3'd3, 32'h1234_0000, 32'h0000_00F0, 32'h4, 5'd0, 1'b0, 1'b0);
        tbl[16] = mk(32'h8C2E_FFFC, 8'hE3, 3'd3, 32'h1234_0000, 32'h0, 32'hFFFF_FFFC, 5'd14, 1'b1, 1'b0);
        tbl[17] = mk(32'h0000_7825, 8'h25, 3'd1, 32'h0, 32'h0, 32'h0, 5'd15, 1'b1, 1'b0);
        tbl[17].ex_en = 1'b1;  tbl[17].ex_wd = 5'd0;  tbl[17].ex_data = 32'h5;
        tbl[17].mem_en = 1'b1; tbl[17].mem_wd = 5'd0; tbl[17].mem_data = 32'h7;
        tbl[17].wb_en = 1'b1;  tbl[17].wb_wd = 5'd0;  tbl[17].wb_data = 32'h9;

        for (int i = 0; i < 18; i++) send(tbl[i], 32'h1000 + 32'(4 * i), 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Load-use: LW in EX targeting $2 while ID reads $2.
        bus.in_valid_i = 1'b1; bus.pc_i = 32'h2000; bus.inst_i = 32'h0040_2825;
        bus.ex_wreg_i = 1'b1; bus.ex_wd_i = 5'd2; bus.ex_wdata_i = 32'h55; bus.ex_is_load_i = 1'b1;
        @(negedge clk);
        chk("lu_in_ready", 64'(bus.in_ready_o), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lu_bubble", 64'(bus.out_valid_o), 64'd0);
        @(posedge clk);
        #1;
        lu = mk(32'h0040_2825, 8'h25, 3'd1, 32'h77, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0);
        lu.mem_en = 1'b1; lu.mem_wd = 5'd2; lu.mem_data = 32'h77;
        send(lu, 32'h2000, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: hold the ID/EX word for three cycles with a new op waiting.
        bus.out_ready_i = 1'b0;
        send(tbl[1], 32'h3000, 1'b1);
        bus.in_valid_i = 1'b1; bus.pc_i = 32'h3004; bus.inst_i = tbl[3].inst;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid_o), 64'd1);
            chk("bp_pc_stable", 64'(bus.pc_o), 64'h3000);
            chk("bp_reg2_stable", 64'(bus.reg2_o), 64'hFFFF_FFFE);
            @(posedge clk);
            #1;
        end
        bus.out_ready_i = 1'b1;
        send(tbl[3], 32'h3004, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Flush with a held op and a pending input: both disappear.
        bus.out_ready_i = 1'b0;
        send(tbl[0], 32'h4000, 1'b0);
        bus.flush_i = 1'b1; bus.in_valid_i = 1'b1; bus.pc_i = 32'h4004; bus.inst_i = tbl[2].inst;
        @(negedge clk);
        chk("fl_in_ready", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("fl_out_valid", 64'(bus.out_valid_o), 64'd0);
        bus.out_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
